// File: rtl/c432_misr.sv
// c432_misr: 16-bit MISR compacting c432 responses with IDLE/RUN/DONE control and golden compare.
// Define MISR_X_MASK_EN to add resp_mask for X-masking response bits before compaction.
module c432_misr #(
  parameter logic [15:0] SEED      = 16'h0000,
  parameter logic [15:0] PAT_COUNT = 16'd256,
  parameter logic [15:0] GOLDEN    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        resp_valid,
  input  logic [6:0]  resp,
`ifdef MISR_X_MASK_EN
  input  logic [6:0]  resp_mask,
`endif
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature,
  output logic [15:0] count
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q, state_d;
  logic [15:0] sig_q, sig_d, cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic [6:0]  vec;
  logic        fb;
`ifdef MISR_X_MASK_EN
  assign vec = resp & ~resp_mask;
`else
  assign vec = resp;
`endif
  assign fb = sig_q[15] ^ sig_q[13] ^ sig_q[12] ^ sig_q[10];
  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      sig_d   = SEED;
      cnt_d   = 16'd0;
      pass_d  = 1'b0;
    end else if (state_q == RUN && resp_valid) begin
      sig_d = {sig_q[14:0], fb} ^ {9'b0, vec};
      cnt_d = cnt_q + 16'd1;
      if (cnt_d == PAT_COUNT) begin
        state_d = DONE;
        pass_d  = (sig_d == GOLDEN);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sig_q   <= 16'h0000;
      cnt_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign count     = cnt_q;
endmodule

// File: tb/tb_c432_misr.sv
// tb_c432_misr: directed checks of three c432_misr configurations sharing one stimulus stream.
module tb_c432_misr;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, resp_valid = 1'b0;
  logic [6:0] resp = 7'h00;
  logic [6:0] resp_mask = 7'h00;
  logic        busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [15:0] sig0, cnt0, sig1, cnt1, sig2, cnt2;
  int total = 0, passed = 0;
  always #5 clk = ~clk;
  c432_misr #(.SEED(16'h0001), .PAT_COUNT(16'd4), .GOLDEN(16'h0010)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_X_MASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(busy0), .done(done0), .pass(pass0), .signature(sig0), .count(cnt0));
  c432_misr #(.SEED(16'h0000), .PAT_COUNT(16'd2), .GOLDEN(16'h0002)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_X_MASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .count(cnt1));
  // Seed sets every tap bit, so the feedback path is actually exercised.
  c432_misr #(.SEED(16'hB400), .PAT_COUNT(16'd2), .GOLDEN(16'h0000)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .resp_valid(resp_valid), .resp(resp),
`ifdef MISR_X_MASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .count(cnt2));
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic rv, input logic [6:0] r);
    start = 1'b1; resp_valid = rv; resp = r;
    tick();
    start = 1'b0; resp_valid = 1'b0;
  endtask
  task automatic vec(input logic [6:0] r);
    resp_valid = 1'b1; resp = r;
    tick();
    resp_valid = 1'b0;
  endtask
  initial begin
    #1;
    check("rst_sig", sig0, 16'h0000);
    check("rst_cnt", cnt0, 16'd0);
    check("rst_flags", {13'd0, busy0, done0, pass0}, 16'd0);
    tick();
    rst_n = 1'b1;
    vec(7'h7F);
    check("idle_ignore", sig0, 16'h0000);
    go(1'b0, 7'h00);
    check("start_sig", sig0, 16'h0001);
    check("start_busy", {15'd0, busy0}, 16'd1);
    vec(7'h00);
    check("a_v1", sig0, 16'h0002);
    check("u2_v1", sig2, 16'h6800);
    go(1'b0, 7'h00);
    check("run_start_sig", sig0, 16'h0002);
    check("run_start_cnt", cnt0, 16'd1);
    tick();
    vec(7'h00);
    check("u2_v2", sig2, 16'hD001);
    check("u2_done", {15'd0, done2}, 16'd1);
    vec(7'h00);
    check("a_v3_sig", sig0, 16'h0008);
    check("a_v3_done", {15'd0, done0}, 16'd0);
    vec(7'h00);
    check("a_sig", sig0, 16'h0010);
    check("a_cnt", cnt0, 16'd4);
    check("a_flags", {13'd0, busy0, done0, pass0}, 16'b011);
    vec(7'h7F);
    tick();
    check("done_hold_sig", sig0, 16'h0010);
    check("done_hold_cnt", cnt0, 16'd4);
    check("done_hold_pass", {15'd0, pass0}, 16'd1);
    go(1'b1, 7'h7F);
    check("restart_sig", sig0, 16'h0001);
    check("restart_cnt", cnt0, 16'd0);
    check("restart_pass", {15'd0, pass0}, 16'd0);
    check("restart_u1", sig1, 16'h0000);
    vec(7'h01);
    check("b_v1", sig0, 16'h0003);
    check("u1_v1", sig1, 16'h0001);
    check("u2_b_v1", sig2, 16'h6801);
    tick();
    tick();
    check("gap_sig", sig1, 16'h0001);
    check("gap_cnt", cnt1, 16'd1);
    vec(7'h00);
    check("u1_v2", sig1, 16'h0002);
    check("u1_flags", {13'd0, busy1, done1, pass1}, 16'b011);
    check("u2_b_v2", sig2, 16'hD003);
    vec(7'h00);
    vec(7'h00);
    check("b_sig", sig0, 16'h0018);
    check("b_flags", {13'd0, busy0, done0, pass0}, 16'b010);
    go(1'b0, 7'h00);
    vec(7'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sig", sig0, 16'h0000);
    check("arst_cnt", cnt0, 16'd0);
    check("arst_busy", {15'd0, busy0}, 16'd0);
    tick();
    rst_n = 1'b1;
    vec(7'h00);
    check("post_rst_idle", {15'd0, busy0}, 16'd0);
    go(1'b0, 7'h00);
    for (int i = 0; i < 4; i++) vec(7'h00);
    check("c_sig", sig0, 16'h0010);
    check("c_pass", {15'd0, pass0}, 16'd1);
`ifdef MISR_X_MASK_EN
    resp_mask = 7'h7F;
    go(1'b0, 7'h00);
    for (int i = 0; i < 4; i++) vec(7'h7F);
    check("mask_sig", sig0, 16'h0010);
    check("mask_pass", {15'd0, pass0}, 16'd1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
